// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// Decode-to-execute pipeline register for the 64-bit in-order pipeline.
// Captures the decoded operands and control of the instruction in decode and
// presents them to the execute stage and its forwarding unit. It also detects
// load-use hazards against the instruction currently in EX, stalls fetch and
// decode for one cycle, and inserts a bubble in their place.
//
// Update priority on each rising clk edge, highest first:
//   reset       -> everything cleared, including the bubble counter
//   in_flush    -> bubble loaded (squashes the decode instruction)
//   in_mem_hold -> register and counter frozen
//   load-use    -> bubble loaded, bubble counter incremented (saturating)
//   otherwise   -> decode instruction captured
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid                   decode stage holds a valid instruction
//   in_rs1/in_rs2/in_rd        register indices (5 bits)
//   in_rs1_used/in_rs2_used    instruction actually reads rs1/rs2
//   in_reg_write               instruction writes rd
//   in_mem_read/in_mem_write   load / store
//   in_alu_op                  ALU operation code
//   in_rs1_data/in_rs2_data    register file read data
//   in_imm, in_pc              sign-extended immediate, instruction PC
//   in_flush                   taken branch resolved in EX
//   in_mem_hold                memory stage busy, freeze the pipeline
//   out_stall_id               combinational: hold PC and IF/ID register
//   out_*                      registered ID/EX contents
//   out_bubble_cnt             load-use bubbles inserted since reset
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int ALU_OP_WIDTH   = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [4:0]                in_rs1,
  input  logic [4:0]                in_rs2,
  input  logic                      in_rs1_used,
  input  logic                      in_rs2_used,
  input  logic [4:0]                in_rd,
  input  logic                      in_reg_write,
  input  logic                      in_mem_read,
  input  logic                      in_mem_write,
  input  logic [ALU_OP_WIDTH-1:0]   in_alu_op,
  input  logic [BUS_DATA_WIDTH-1:0] in_rs1_data,
  input  logic [BUS_DATA_WIDTH-1:0] in_rs2_data,
  input  logic [BUS_DATA_WIDTH-1:0] in_imm,
  input  logic [BUS_DATA_WIDTH-1:0] in_pc,
  input  logic                      in_flush,
  input  logic                      in_mem_hold,
  output logic                      out_stall_id,
  output logic                      out_valid,
  output logic [4:0]                out_rs1,
  output logic [4:0]                out_rs2,
  output logic [4:0]                out_rd,
  output logic                      out_reg_write,
  output logic                      out_mem_read,
  output logic                      out_mem_write,
  output logic [ALU_OP_WIDTH-1:0]   out_alu_op,
  output logic [BUS_DATA_WIDTH-1:0] out_rs1_data,
  output logic [BUS_DATA_WIDTH-1:0] out_rs2_data,
  output logic [BUS_DATA_WIDTH-1:0] out_imm,
  output logic [BUS_DATA_WIDTH-1:0] out_pc,
  output logic [CNT_WIDTH-1:0]      out_bubble_cnt
);

  // One ID/EX entry. An all-zero entry is exactly a bubble.
  typedef struct packed {
    logic                      valid;
    logic [4:0]                rs1;
    logic [4:0]                rs2;
    logic [4:0]                rd;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic [ALU_OP_WIDTH-1:0]   alu_op;
    logic [BUS_DATA_WIDTH-1:0] rs1_data;
    logic [BUS_DATA_WIDTH-1:0] rs2_data;
    logic [BUS_DATA_WIDTH-1:0] imm;
    logic [BUS_DATA_WIDTH-1:0] pc;
  } id_ex_t;

  id_ex_t               stage_q;
  id_ex_t               capture;
  logic [CNT_WIDTH-1:0] bubble_cnt_q;
  logic                 ex_is_load;
  logic                 rs1_hit;
  logic                 rs2_hit;
  logic                 load_use;

  // -------------------------------------------------------------------------
  // Load-use detection against the instruction currently in EX. A load to x0
  // never produces a value worth waiting for, so it is excluded.
  // -------------------------------------------------------------------------
  assign ex_is_load = stage_q.valid & stage_q.mem_read & (stage_q.rd != 5'd0);
  assign rs1_hit    = in_rs1_used & (in_rs1 == stage_q.rd);
  assign rs2_hit    = in_rs2_used & (in_rs2 == stage_q.rd);
  assign load_use   = ex_is_load & in_valid & (rs1_hit | rs2_hit);

  // A flush squashes the decode instruction anyway, so a hazard it carries
  // must not stall fetch; a memory hold freezes everything regardless.
  assign out_stall_id = ~reset & (in_mem_hold | (load_use & ~in_flush));

  // -------------------------------------------------------------------------
  // Next entry for the normal (capture) case. An invalid decode slot keeps
  // its data but drops every control bit, so the forwarding unit never sees
  // a stale RegWrite from a non-instruction.
  // -------------------------------------------------------------------------
  // NOTE: every field is assigned before any conditional override so this
  // block stays purely combinational and no latch is inferred.
  always_comb begin
    capture           = '0;
    capture.valid     = in_valid;
    capture.rs1       = in_rs1;
    capture.rs2       = in_rs2;
    capture.rd        = in_rd;
    capture.reg_write = in_reg_write;
    capture.mem_read  = in_mem_read;
    capture.mem_write = in_mem_write;
    capture.alu_op    = in_alu_op;
    capture.rs1_data  = in_rs1_data;
    capture.rs2_data  = in_rs2_data;
    capture.imm       = in_imm;
    capture.pc        = in_pc;
    if (!in_valid) begin
      capture.reg_write = 1'b0;
      capture.mem_read  = 1'b0;
      capture.mem_write = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline register and bubble counter. Reset is synchronous so it is
  // sampled like any other input and overrides flush, hold and hazards.
  // -------------------------------------------------------------------------
  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
    end else if (in_flush) begin
      stage_q <= '0;
    end else if (in_mem_hold) begin
      stage_q      <= stage_q;
      bubble_cnt_q <= bubble_cnt_q;
    end else if (load_use) begin
      stage_q <= '0;
      if (bubble_cnt_q != '1) begin
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end
    end else begin
      stage_q <= capture;
    end
  end

  assign out_valid      = stage_q.valid;
  assign out_rs1        = stage_q.rs1;
  assign out_rs2        = stage_q.rs2;
  assign out_rd         = stage_q.rd;
  assign out_reg_write  = stage_q.reg_write;
  assign out_mem_read   = stage_q.mem_read;
  assign out_mem_write  = stage_q.mem_write;
  assign out_alu_op     = stage_q.alu_op;
  assign out_rs1_data   = stage_q.rs1_data;
  assign out_rs2_data   = stage_q.rs2_data;
  assign out_imm        = stage_q.imm;
  assign out_pc         = stage_q.pc;
  assign out_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Scoreboard bench for id_ex_stage_reg. The driver applies one stimulus per
// cycle on the falling edge and pushes the reference model's expectations:
// the stall level for the current cycle and the register contents after the
// next rising edge. Two monitors pop and compare independently. A second
// instance with a 3-bit counter exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam int W = 64;

  typedef struct packed {
    logic       reset;
    logic       flush;
    logic       hold;
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1_used;
    logic       rs2_used;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] alu_op;
    logic [W-1:0] rs1_data;
    logic [W-1:0] rs2_data;
    logic [W-1:0] imm;
    logic [W-1:0] pc;
  } stim_t;

  // Contents of the EX slot as the model sees it, plus both counters.
  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] alu_op;
    logic [W-1:0] rs1_data;
    logic [W-1:0] rs2_data;
    logic [W-1:0] imm;
    logic [W-1:0] pc;
    logic [31:0] cnt;
    logic [2:0]  cnt_small;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, in_rs1_used, in_rs2_used, in_reg_write;
  logic         in_mem_read, in_mem_write, in_flush, in_mem_hold;
  logic [4:0]   in_rs1, in_rs2, in_rd, in_alu_op;
  logic [W-1:0] in_rs1_data, in_rs2_data, in_imm, in_pc;

  logic         out_stall_id, out_valid, out_reg_write, out_mem_read, out_mem_write;
  logic [4:0]   out_rs1, out_rs2, out_rd, out_alu_op;
  logic [W-1:0] out_rs1_data, out_rs2_data, out_imm, out_pc;
  logic [31:0]  out_bubble_cnt;

  logic         s_stall_id, s_valid, s_reg_write, s_mem_read, s_mem_write;
  logic [4:0]   s_rs1, s_rs2, s_rd, s_alu_op;
  logic [W-1:0] s_rs1_data, s_rs2_data, s_imm, s_pc;
  logic [2:0]   s_bubble_cnt;

  id_ex_stage_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_alu_op(in_alu_op),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
    .in_flush(in_flush), .in_mem_hold(in_mem_hold), .out_stall_id(out_stall_id),
    .out_valid(out_valid), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_alu_op(out_alu_op), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_pc(out_pc), .out_bubble_cnt(out_bubble_cnt)
  );

  id_ex_stage_reg #(.CNT_WIDTH(3)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_alu_op(in_alu_op),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
    .in_flush(in_flush), .in_mem_hold(in_mem_hold), .out_stall_id(s_stall_id),
    .out_valid(s_valid), .out_rs1(s_rs1), .out_rs2(s_rs2), .out_rd(s_rd),
    .out_reg_write(s_reg_write), .out_mem_read(s_mem_read), .out_mem_write(s_mem_write),
    .out_alu_op(s_alu_op), .out_rs1_data(s_rs1_data), .out_rs2_data(s_rs2_data),
    .out_imm(s_imm), .out_pc(s_pc), .out_bubble_cnt(s_bubble_cnt)
  );

  int compared   = 0;
  int mismatched = 0;

  logic stall_q[$];
  exp_t state_q[$];
  exp_t model;

  task automatic check(input string name, input logic [511:0] actual, input logic [511:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // Reference model: what ends up in EX after one edge, expressed as the
  // pipeline's rules rather than as a register description.
  function automatic exp_t model_step(input exp_t e, input stim_t s, output logic stall);
    exp_t n;
    logic waits_on_load;
    logic ex_load_useful;
    ex_load_useful = e.valid && e.mem_read && (e.rd != 0);
    waits_on_load  = ex_load_useful && s.valid &&
                     ((s.rs1_used && s.rs1 == e.rd) || (s.rs2_used && s.rs2 == e.rd));
    stall = !s.reset && (s.hold || (waits_on_load && !s.flush));
    n = e;
    if (s.reset) begin
      n = '0;
    end else if (s.flush) begin
      n = '0;
      n.cnt = e.cnt;
      n.cnt_small = e.cnt_small;
    end else if (s.hold) begin
      n = e;
    end else if (waits_on_load) begin
      n = '0;
      n.cnt       = (e.cnt == 32'hFFFF_FFFF) ? e.cnt : e.cnt + 32'd1;
      n.cnt_small = (e.cnt_small == 3'd7) ? e.cnt_small : e.cnt_small + 3'd1;
    end else begin
      n.valid     = s.valid;
      n.rs1       = s.rs1;
      n.rs2       = s.rs2;
      n.rd        = s.rd;
      n.reg_write = s.valid ? s.reg_write : 1'b0;
      n.mem_read  = s.valid ? s.mem_read  : 1'b0;
      n.mem_write = s.valid ? s.mem_write : 1'b0;
      n.alu_op    = s.alu_op;
      n.rs1_data  = s.rs1_data;
      n.rs2_data  = s.rs2_data;
      n.imm       = s.imm;
      n.pc        = s.pc;
    end
    return n;
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic stim_t instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                  input logic u2, input logic [4:0] rd, input logic rw,
                                  input logic mr);
    stim_t s;
    s = '0;
    s.valid = 1'b1;
    s.rs1 = rs1; s.rs1_used = u1;
    s.rs2 = rs2; s.rs2_used = u2;
    s.rd = rd; s.reg_write = rw; s.mem_read = mr;
    s.alu_op = 5'($urandom_range(0, 31));
    s.rs1_data = rand64(); s.rs2_data = rand64();
    s.imm = rand64(); s.pc = rand64();
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = instr(5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
              5'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 2) == 0));
    s.valid     = ($urandom_range(0, 7) != 0);
    s.mem_write = 1'($urandom);
    s.flush     = ($urandom_range(0, 7) == 0);
    s.hold      = ($urandom_range(0, 5) == 0);
    s.reset     = ($urandom_range(0, 49) == 0);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    logic stall;
    @(negedge clk);
    reset        = s.reset;
    in_flush     = s.flush;
    in_mem_hold  = s.hold;
    in_valid     = s.valid;
    in_rs1       = s.rs1;
    in_rs2       = s.rs2;
    in_rd        = s.rd;
    in_rs1_used  = s.rs1_used;
    in_rs2_used  = s.rs2_used;
    in_reg_write = s.reg_write;
    in_mem_read  = s.mem_read;
    in_mem_write = s.mem_write;
    in_alu_op    = s.alu_op;
    in_rs1_data  = s.rs1_data;
    in_rs2_data  = s.rs2_data;
    in_imm       = s.imm;
    in_pc        = s.pc;
    model = model_step(model, s, stall);
    stall_q.push_back(stall);
    state_q.push_back(model);
  endtask

  // Stall monitor: combinational output, sampled shortly after the inputs move.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (stall_q.size() > 0) begin
        logic e;
        e = stall_q.pop_front();
        check("stall_id", 512'(out_stall_id), 512'(e));
        check("stall_id_small", 512'(s_stall_id), 512'(e));
      end
    end
  end

  // Register monitor: sampled just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (state_q.size() > 0) begin
        exp_t e, a;
        e = state_q.pop_front();
        a.valid = out_valid; a.rs1 = out_rs1; a.rs2 = out_rs2; a.rd = out_rd;
        a.reg_write = out_reg_write; a.mem_read = out_mem_read; a.mem_write = out_mem_write;
        a.alu_op = out_alu_op; a.rs1_data = out_rs1_data; a.rs2_data = out_rs2_data;
        a.imm = out_imm; a.pc = out_pc; a.cnt = out_bubble_cnt; a.cnt_small = s_bubble_cnt;
        check("id_ex_state", 512'(a), 512'(e));
        check("small_ctrl", 512'({s_valid, s_rd, s_reg_write, s_mem_read, s_mem_write}),
              512'({e.valid, e.rd, e.reg_write, e.mem_read, e.mem_write}));
      end
    end
  end

  initial begin
    stim_t s;
    model = '0;
    {reset, in_flush, in_mem_hold, in_valid, in_rs1_used, in_rs2_used} = '0;
    {in_reg_write, in_mem_read, in_mem_write} = '0;
    {in_rs1, in_rs2, in_rd, in_alu_op} = '0;
    {in_rs1_data, in_rs2_data, in_imm, in_pc} = '0;

    // Reset with random inputs, including flush/hold noise.
    for (int i = 0; i < 2; i++) begin
      s = rand_stim();
      s.reset = 1'b1;
      s.hold  = 1'b1;
      apply(s);
    end

    // Pass-through.
    s = instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    s.imm = 64'h10; s.pc = 64'h1000;
    apply(s);

    // Load-use on rs1: stall, bubble, then capture of the held instruction.
    apply(instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1));
    s = instr(5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
    apply(s);
    apply(s);

    // Load to x0, and load to x7 with an unused matching rs2.
    apply(instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1));
    apply(instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0));
    apply(instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1));
    apply(instr(5'd3, 1'b1, 5'd7, 1'b0, 5'd9, 1'b1, 1'b0));

    // Store after load on rs2 still stalls.
    apply(instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1));
    s = instr(5'd2, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
    s.mem_write = 1'b1;
    apply(s);
    apply(s);

    // Flush together with a hazard.
    apply(instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1));
    s = instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    s.flush = 1'b1;
    apply(s);

    // Hold for three cycles during a hazard, then release.
    apply(instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1));
    s = instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    s.hold = 1'b1;
    for (int i = 0; i < 3; i++) apply(s);
    s.hold = 1'b0;
    apply(s);
    apply(s);

    // Back-to-back self-dependent loads: a bubble every other cycle drives
    // the 3-bit counter into saturation.
    for (int i = 0; i < 24; i++) apply(instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1));

    // Randomized traffic.
    for (int i = 0; i < 600; i++) apply(rand_stim());

    // Drain with idle cycles, bounded.
    s = '0;
    for (int i = 0; i < 10 && (state_q.size() > 0 || stall_q.size() > 0); i++) apply(s);
    @(posedge clk);
    #3;
    for (int i = 0; i < 10 && (state_q.size() > 0 || stall_q.size() > 0); i++) @(posedge clk);
    #3;
    if (state_q.size() > 0 || stall_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d/%0d expectations left, required 0", state_q.size(), stall_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register for the 64-bit in-order RISC pipeline, sitting directly upstream of the execute-stage forwarding unit.
- Captures decoded operands and control each cycle, and supplies the rs1/rs2/rd indices and RegWrite flag that the forwarding unit compares.
- Detects load-use hazards, stalls fetch/decode and inserts bubbles.
- Honours a branch flush and a memory-stage hold, and keeps a saturating bubble counter.

Parameters:
- BUS_DATA_WIDTH, 64: width of register data, immediate and PC.
- ALU_OP_WIDTH, 5: width of the ALU operation code.
- CNT_WIDTH, 32: width of the load-use bubble counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  decode stage holds a valid instruction
- in_rs1  input  5  source register 1 index
- in_rs2  input  5  source register 2 index
- in_rs1_used  input  1  instruction reads rs1
- in_rs2_used  input  1  instruction reads rs2
- in_rd  input  5  destination index
- in_reg_write  input  1  instruction writes rd
- in_mem_read  input  1  instruction is a load
- in_mem_write  input  1  instruction is a store
- in_alu_op  input  ALU_OP_WIDTH  ALU operation
- in_rs1_data  input  BUS_DATA_WIDTH  register file read 1
- in_rs2_data  input  BUS_DATA_WIDTH  register file read 2
- in_imm  input  BUS_DATA_WIDTH  sign-extended immediate
- in_pc  input  BUS_DATA_WIDTH  instruction PC
- in_flush  input  1  taken branch/jump resolved in EX; squash decode instruction
- in_mem_hold  input  1  memory stage busy; freeze whole pipeline
- out_stall_id  output  1  combinational: hold PC and IF/ID register
- out_valid, out_rs1, out_rs2, out_rd, out_reg_write, out_mem_read, out_mem_write, out_alu_op, out_rs1_data, out_rs2_data, out_imm, out_pc  output  (widths as inputs)  registered ID/EX contents
- out_bubble_cnt  output  CNT_WIDTH  load-use bubbles inserted since reset

Behaviour:
- Reset: synchronous and active-high. On any clk edge with reset=1, every registered output and out_bubble_cnt becomes 0. Reset overrides all other inputs, including mid-stall or mid-hold.
- Load-use hazard (combinational), lu:
  - out_valid & out_mem_read & (out_rd != 0) & in_valid, and
  - ((in_rs1_used & in_rs1 == out_rd) | (in_rs2_used & in_rs2 == out_rd)).
- out_stall_id = in_mem_hold | (lu & ~in_flush). Output is 0 during reset.
- Per-edge update priority, highest first:
  1. reset: clear everything.
  2. in_flush: load a bubble. Flush wins over both hold and lu.
  3. in_mem_hold: all outputs hold their value; counter holds.
  4. lu: load a bubble; out_bubble_cnt += 1, saturating at all-ones.
  5. otherwise: capture all in_* fields. out_valid = in_valid.
- Bubble contents: out_valid, out_reg_write, out_mem_read and out_mem_write are 0; all other fields are 0.
- If in_valid=0 in the normal case, control fields are forced to 0 so the forwarding unit never sees a stale RegWrite.
- Latency: one cycle from decode inputs to outputs.
- Stall length: a load-use stall lasts exactly one cycle, because the bubble clears out_mem_read. The decode instruction then enters ID/EX on the following edge, provided no hold or flush occurs.
- A hazard that persists through a hold counts only once, at the edge where the bubble is inserted.
- Stores: loads followed by a store whose rs2 matches still stall; there is no store-data bypass.
- out_rd = 0 never causes a stall.

Test Plan:
- Reset: drive random inputs with reset=1 for 2 cycles. All outputs are 0, out_stall_id=0 and out_bubble_cnt=0.
- Pass-through: in_valid=1, rs1=1, rs2=2, rd=3, reg_write=1, imm=0x10, pc=0x1000. The next cycle shows identical outputs with out_valid=1, and out_stall_id stays 0.
- Load-use: EX holds ld x5 (out_mem_read=1, out_rd=5) and decode has rs1=5, rs1_used=1.
  - out_stall_id=1 in the same cycle.
  - The next cycle shows out_valid=0 with all control fields 0, and out_bubble_cnt=1.
  - The cycle after that captures the decode instruction, and out_stall_id=0.
- Load to x0 / unused operand:
  - out_rd=0 with rs1=0 gives no stall.
  - out_rd=7 with rs2=7 but rs2_used=0 gives no stall.
- Flush plus hazard: lu=1 and in_flush=1 in the same cycle give out_stall_id=0, a bubble on the next cycle, and out_bubble_cnt unchanged.
- Hold: in_mem_hold=1 for 3 cycles while lu=1. Outputs are frozen, out_stall_id=1 throughout and the counter is unchanged. After hold drops, one bubble is inserted and the count increments by exactly 1. Counter saturation is checked by forcing the count to 0xFFFFFFFF, then triggering lu; it stays 0xFFFFFFFF.
